// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: queues ALU (A) and load (B) writebacks and merges them onto one register-file write port.
// Build option: define RF_ARB_ROUND_ROBIN_EN for round-robin grant; otherwise B (load) has fixed priority.
module rf_write_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_din,
  output logic [31:0] pending
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [4:0]    q_rd   [2][DEPTH];
  logic [31:0]   q_data [2][DEPTH];
  logic [PW-1:0] wp [2];
  logic [PW-1:0] rp [2];
  logic [CW-1:0] cnt [2];
  logic          in_valid [2];
  logic [4:0]    in_rd [2];
  logic [31:0]   in_data [2];
  logic          ready [2];
  logic          push [2];
  logic          pop [2];
  logic          ne [2];
  logic          any;
  logic          gnt_b;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;
  // Index 0 is requester A, index 1 is requester B.
  assign in_valid[0] = a_valid;
  assign in_valid[1] = b_valid;
  assign in_rd[0]    = a_rd;
  assign in_rd[1]    = b_rd;
  assign in_data[0]  = a_data;
  assign in_data[1]  = b_data;
  assign a_ready     = ready[0];
  assign b_ready     = ready[1];
  // Ready depends only on registered occupancy; writes to x0 are accepted but never queued.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ready[i] = cnt[i] != CW'(DEPTH);
      ne[i]    = cnt[i] != '0;
      push[i]  = in_valid[i] & ready[i] & (in_rd[i] != 5'd0);
    end
  end
  assign any = ne[0] | ne[1];
`ifdef RF_ARB_ROUND_ROBIN_EN
  logic rr;
  assign gnt_b = ne[1] & (~ne[0] | rr);
  // Preference moves to the queue that was not granted, so contention alternates.
  always_ff @(posedge clk) begin
    if (reset) rr <= 1'b0;
    else if (any) rr <= ~gnt_b;
  end
`else
  assign gnt_b = ne[1];
`endif
  assign pop[0]    = ne[0] & ~gnt_b;
  assign pop[1]    = gnt_b;
  assign head_rd   = gnt_b ? q_rd[1][rp[1]] : q_rd[0][rp[0]];
  assign head_data = gnt_b ? q_data[1][rp[1]] : q_data[0][rp[0]];
  // Queue storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        q_rd[i][wp[i]]   <= in_rd[i];
        q_data[i][wp[i]] <= in_data[i];
      end
    end
  end
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        wp[i]  <= '0;
        rp[i]  <= '0;
        cnt[i] <= '0;
      end else begin
        if (push[i]) wp[i] <= wp[i] + PW'(1);
        if (pop[i]) rp[i] <= rp[i] + PW'(1);
        cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  end
  // One granted head per cycle drives the registered write port; address and data hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we  <= 1'b0;
      rf_rd  <= '0;
      rf_din <= '0;
    end else begin
      rf_we <= any;
      if (any) begin
        rf_rd  <= head_rd;
        rf_din <= head_data;
      end
    end
  end
  // Scoreboard bits: every live queue entry plus the write currently on the port.
  always_comb begin
    logic [PW-1:0] off;
    pending = '0;
    off     = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        off = PW'(j) - rp[i];
        if (CW'(off) < cnt[i]) pending[q_rd[i][j]] = 1'b1;
      end
    end
    if (rf_we) pending[rf_rd] = 1'b1;
    pending[0] = 1'b0;
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: vector table, contention/reset sequences and randomized run against a queue-based model.
module tb_rf_write_arbiter;
  localparam int DEPTH = 2;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [4:0]  a_rd = '0, b_rd = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_din;
  logic [31:0] pending;
  always #5 clk = ~clk;
  rf_write_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_din(rf_din), .pending(pending)
  );
  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
  typedef struct {
    logic rs; logic av; logic [4:0] ar; logic [31:0] ad;
    logic bv; logic [4:0] br; logic [31:0] bd;
    logic we; logic [4:0] rd; logic [31:0] din; logic [31:0] pend; logic ardy; logic brdy;
  } vec_t;
  ent_t        qa[$], qb[$];
  logic        m_we = 1'b0, m_rr = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_din = '0;
  logic        acc_a, acc_b;
  int          checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] m_pend();
    logic [31:0] p = '0;
    foreach (qa[i]) p[qa[i].rd] = 1'b1;
    foreach (qb[i]) p[qb[i].rd] = 1'b1;
    if (m_we) p[m_rd] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction
  task automatic step(input logic rs, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic bv, input logic [4:0] br, input logic [31:0] bd);
    ent_t e;
    logic use_b;
    reset = rs; a_valid = av; a_rd = ar; a_data = ad; b_valid = bv; b_rd = br; b_data = bd;
    @(posedge clk);
    acc_a = !rs && av && qa.size() < DEPTH;
    acc_b = !rs && bv && qb.size() < DEPTH;
    if (rs) begin
      qa.delete(); qb.delete();
      m_we = 1'b0; m_rd = '0; m_din = '0; m_rr = 1'b0;
    end else begin
      if (qa.size() + qb.size() > 0) begin
`ifdef RF_ARB_ROUND_ROBIN_EN
        use_b = qb.size() > 0 && (qa.size() == 0 || m_rr);
`else
        use_b = qb.size() > 0;
`endif
        if (use_b) e = qb.pop_front();
        else e = qa.pop_front();
        m_we = 1'b1; m_rd = e.rd; m_din = e.data; m_rr = !use_b;
      end else m_we = 1'b0;
      if (acc_a && ar != 0) qa.push_back('{ar, ad});
      if (acc_b && br != 0) qb.push_back('{br, bd});
    end
    @(negedge clk);
  endtask
  task automatic check_model();
    chk("model_we", 32'(rf_we), 32'(m_we));
    chk("model_rd", 32'(rf_rd), 32'(m_rd));
    chk("model_din", rf_din, m_din);
    chk("model_pending", pending, m_pend());
    chk("model_a_ready", 32'(a_ready), 32'(qa.size() < DEPTH));
    chk("model_b_ready", 32'(b_ready), 32'(qb.size() < DEPTH));
  endtask
  initial begin
    vec_t        tbl[7];
    logic [4:0]  ea[3], eb[3], ord[6], got[$];
    logic        saw_full, hv_a, hv_b;
    logic [4:0]  r_ar, r_br;
    logic [31:0] r_ad, r_bd;
    int          ai, bi, first, last;
    tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[1] = '{1, 1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[2] = '{0, 1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 32'h20, 1, 1};
    tbl[3] = '{0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h1234, 32'h20, 1, 1};
    tbl[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 5, 32'h1234, 0, 1, 1};
    tbl[5] = '{0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 5, 32'h1234, 0, 1, 1};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 0, 0, 5, 32'h1234, 0, 1, 1};
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].rs, tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].bv, tbl[i].br, tbl[i].bd);
      chk($sformatf("vec%0d_we", i), 32'(rf_we), 32'(tbl[i].we));
      chk($sformatf("vec%0d_rd", i), 32'(rf_rd), 32'(tbl[i].rd));
      chk($sformatf("vec%0d_din", i), rf_din, tbl[i].din);
      chk($sformatf("vec%0d_pending", i), pending, tbl[i].pend);
      chk($sformatf("vec%0d_a_ready", i), 32'(a_ready), 32'(tbl[i].ardy));
      chk($sformatf("vec%0d_b_ready", i), 32'(b_ready), 32'(tbl[i].brdy));
    end
    ea = '{5'd1, 5'd2, 5'd3};
    eb = '{5'd11, 5'd12, 5'd13};
`ifdef RF_ARB_ROUND_ROBIN_EN
    ord = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13};
`else
    ord = '{5'd11, 5'd12, 5'd13, 5'd1, 5'd2, 5'd3};
`endif
    step(1, 0, 0, 0, 0, 0, 0);
    ai = 0; bi = 0; first = -1; last = -1; saw_full = 1'b0;
    for (int c = 0; c < 16; c++) begin
      step(0, ai < 3, ai < 3 ? ea[ai] : 5'd0, 32'h100 + 32'(ai),
              bi < 3, bi < 3 ? eb[bi] : 5'd0, 32'h200 + 32'(bi));
      if (acc_a) ai++;
      if (acc_b) bi++;
      check_model();
      if (!a_ready) saw_full = 1'b1;
      if (rf_we) begin
        got.push_back(rf_rd);
        if (first < 0) first = c;
        last = c;
      end
    end
    chk("contention_count", 32'(got.size()), 32'd6);
    for (int i = 0; i < 6 && i < got.size(); i++) chk($sformatf("contention_order%0d", i), 32'(got[i]), 32'(ord[i]));
    chk("contention_back_to_back", 32'(last - first), 32'd5);
    chk("contention_a_full_seen", 32'(saw_full), 32'd1);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 7, 32'h77, 1, 9, 32'h99);
    check_model();
    step(0, 1, 8, 32'h88, 1, 10, 32'haa);
    check_model();
    step(1, 0, 0, 0, 0, 0, 0);
    chk("reset_mid_we", 32'(rf_we), 32'd0);
    chk("reset_mid_pending", pending, 32'd0);
    chk("reset_mid_a_ready", 32'(a_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      chk("reset_mid_no_ghost_we", 32'(rf_we), 32'd0);
      chk("reset_mid_no_ghost_pending", pending, 32'd0);
    end
    r_ar = 5'd1 + 5'($urandom_range(0, 30));
    r_br = 5'd1 + 5'($urandom_range(0, 30));
    r_ad = $urandom; r_bd = $urandom;
    for (int c = 0; c < 300; c++) begin
      step(0, 1, r_ar, r_ad, 1, r_br, r_bd);
      check_model();
      if (acc_a) begin r_ar = 5'd1 + 5'($urandom_range(0, 30)); r_ad = $urandom; end
      if (acc_b) begin r_br = 5'd1 + 5'($urandom_range(0, 30)); r_bd = $urandom; end
    end
    hv_a = 1'b0; hv_b = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!hv_a) begin
        hv_a = $urandom_range(0, 2) != 0;
        r_ar = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        r_ad = $urandom;
      end
      if (!hv_b) begin
        hv_b = $urandom_range(0, 2) != 0;
        r_br = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        r_bd = $urandom;
      end
      step($urandom_range(0, 60) == 0, hv_a, r_ar, r_ad, hv_b, r_br, r_bd);
      check_model();
      if (reset || acc_a) hv_a = 1'b0;
      if (reset || acc_b) hv_b = 1'b0;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: entries per requester queue, power of two, minimum 2.
REQ-002 clk  input  1  clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 a_valid  input  1  requester A (ALU writeback) has a write.
REQ-005 a_ready  output  1  queue A can accept.
REQ-006 a_rd  input  5  destination register of A.
REQ-007 a_data  input  32  write data of A.
REQ-008 b_valid  input  1  requester B (load writeback) has a write.
REQ-009 b_ready  output  1  queue B can accept.
REQ-010 b_rd  input  5  destination register of B.
REQ-011 b_data  input  32  write data of B.
REQ-012 rf_we  output  1  register file write enable, registered.
REQ-013 rf_rd  output  5  register file write address, registered.
REQ-014 rf_din  output  32  register file write data, registered.
REQ-015 pending  output  32  bit r set while any queued or in-flight write targets register r.

Function
REQ-016 Handshake: a transfer on A or B occurs at an edge where valid and ready are both 1; valid/rd/data are held by the requester until then.
REQ-017 a_ready is 1 exactly when queue A holds fewer than DEPTH entries, computed from registered occupancy only (same for B).
REQ-018 A transfer with rd = 0 is accepted and discarded: it never enters a queue, never sets pending, never produces rf_we.
REQ-019 Each queue is FIFO; entries from one requester are written in acceptance order.
REQ-020 At each edge, if at least one queue is non-empty, exactly one head is popped (the grant) and loaded into rf_we=1/rf_rd/rf_din; otherwise rf_we is loaded with 0 and rf_rd/rf_din hold.
REQ-021 Latency: an entry accepted at edge E into an empty queue with no competing head is popped at edge E+1, so rf_we=1 during the cycle after E+1 and the register file captures at edge E+2.
REQ-022 Sustained throughput: one register write per cycle while either queue is non-empty.
REQ-023 Push and pop on the same queue at the same edge are both performed; occupancy is unchanged.
REQ-024 pending[r] = OR over all valid queue entries with rd = r, OR (rf_we and rf_rd = r); pending[0] is always 0.
REQ-025 Same rd at both heads: granted per arbitration policy with no reordering between requesters; ordering across requesters is the issuer's responsibility.
REQ-026 Pointers wrap modulo DEPTH; a full queue never overwrites, an empty queue never pops.

Reset
REQ-027 While reset is 1 at an edge: both queues emptied, rf_we=0, rf_rd=0, rf_din=0, round-robin pointer = A, pending=0.
REQ-028 Reset mid-operation discards all queued entries; no rf_we pulse is produced for them after reset.
REQ-029 a_ready and b_ready are 1 in the first cycle after reset deasserts; transfers presented during reset are not accepted.

Configuration
REQ-030 Macro RF_ARB_ROUND_ROBIN_EN defined: round-robin grant; pointer names the preferred queue, toggles to the other queue after each grant when both were non-empty, otherwise stays at the queue not granted.
REQ-031 Macro RF_ARB_ROUND_ROBIN_EN undefined: fixed priority, B (load) always wins when both heads are valid; no pointer state exists.

Verification
REQ-032 Single write: reset, then a_valid=1 a_rd=5 a_data=0x1234 for one accepted cycle -> rf_we=1 rf_rd=5 rf_din=0x1234 exactly one cycle, two edges after acceptance; pending[5]=1 from acceptance edge until after the rf_we cycle.
REQ-033 x0 drop: b_valid=1 b_rd=0 b_data=0xFFFFFFFF accepted -> no rf_we, pending stays 0.
REQ-034 Contention: A and B each push 3 entries (rd 1,2,3 / 11,12,13) back-to-back -> 6 consecutive rf_we cycles; round-robin order 1,11,2,12,3,13; fixed-priority order 11,12,13,1,2,3; a_ready drops to 0 while queue A is full.
REQ-035 Full/backpressure: DEPTH=2, B held valid, A flooding -> b_ready/a_ready never 1 when full, no entry lost or duplicated (scoreboard compare).
REQ-036 Reset mid-stream: 2 entries queued in A, reset for one cycle -> rf_we=0 and pending=0 after the reset edge, the discarded entries never appear on rf_we.
